// File: rtl/cpu_loader.sv
// Boot loader: streams a program image into the CPU's instruction and data memories, then enables the CPU.
// Optional write-readback checking is compiled in with `define CPU_LOADER_VERIFY_EN.
module cpu_loader #(
  parameter int unsigned IMEM_DEPTH = 512,
  parameter int unsigned DMEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        start,
  input  logic [9:0]  imem_words,
  input  logic [10:0] dmem_words,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic [31:0] imem_addr_ext,
  output logic        imem_wen_ext,
  output logic        imem_ren_ext,
  output logic [31:0] imem_wdata_ext,
  input  logic [31:0] imem_rdata_ext,
  output logic [31:0] dmem_addr_ext,
  output logic        dmem_wen_ext,
  output logic        dmem_ren_ext,
  output logic [31:0] dmem_wdata_ext,
  input  logic [31:0] dmem_rdata_ext,
  output logic        cpu_enable,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] cycle_count
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_I,
    LOAD_D,
`ifdef CPU_LOADER_VERIFY_EN
    VERIFY,
`endif
    RUN,
    ERROR
  } state_t;

  localparam logic [10:0] IMEM_MAX = 11'(IMEM_DEPTH);
  localparam logic [10:0] DMEM_MAX = 11'(DMEM_DEPTH);

  state_t      state;
  logic [10:0] imem_cnt;
  logic [10:0] dmem_cnt;
  logic [10:0] word_idx;

  logic        handshake;
  logic        last_word;
  logic        overflow;
  logic [10:0] sec_len;
  logic [10:0] idx_next;
  logic [31:0] word_addr;

  assign in_ready  = (state == LOAD_I) || (state == LOAD_D);
  assign handshake = in_valid && in_ready;
  assign sec_len   = (state == LOAD_I) ? imem_cnt : dmem_cnt;
  assign idx_next  = word_idx + 11'd1;
  // The index never reaches the count while loading, so equality with idx+1 marks the final word.
  assign last_word = (idx_next == sec_len);
  assign word_addr = {19'd0, word_idx, 2'b00};
  assign overflow  = ({1'b0, imem_words} > IMEM_MAX) || (dmem_words > DMEM_MAX);
  assign error     = (state == ERROR);

`ifdef CPU_LOADER_VERIFY_EN
  logic        v_dmem;
  logic        v_last;
  logic [31:0] v_data;
  logic [1:0]  v_phase;
  logic [31:0] v_rdata;

  assign busy    = in_ready || (state == VERIFY);
  assign v_rdata = v_dmem ? dmem_rdata_ext : imem_rdata_ext;
`else
  logic unused_rdata;

  assign busy         = in_ready;
  assign imem_ren_ext = 1'b0;
  assign dmem_ren_ext = 1'b0;
  assign unused_rdata = ^{imem_rdata_ext, dmem_rdata_ext};
`endif

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state          <= IDLE;
      imem_cnt       <= '0;
      dmem_cnt       <= '0;
      word_idx       <= '0;
      imem_addr_ext  <= '0;
      imem_wen_ext   <= 1'b0;
      imem_wdata_ext <= '0;
      dmem_addr_ext  <= '0;
      dmem_wen_ext   <= 1'b0;
      dmem_wdata_ext <= '0;
      cpu_enable     <= 1'b0;
      done           <= 1'b0;
      cycle_count    <= '0;
`ifdef CPU_LOADER_VERIFY_EN
      imem_ren_ext   <= 1'b0;
      dmem_ren_ext   <= 1'b0;
      v_dmem         <= 1'b0;
      v_last         <= 1'b0;
      v_data         <= '0;
      v_phase        <= '0;
`endif
    end else begin
      imem_wen_ext <= 1'b0;
      dmem_wen_ext <= 1'b0;
      done         <= 1'b0;
`ifdef CPU_LOADER_VERIFY_EN
      imem_ren_ext <= 1'b0;
      dmem_ren_ext <= 1'b0;
`endif
      if (cpu_enable && (cycle_count != '1)) cycle_count <= cycle_count + 32'd1;

      case (state)
        IDLE, RUN, ERROR: begin
          if (start) begin
            imem_cnt    <= {1'b0, imem_words};
            dmem_cnt    <= dmem_words;
            word_idx    <= '0;
            cycle_count <= '0;
            cpu_enable  <= 1'b0;
            if (overflow) begin
              state <= ERROR;
            end else if (imem_words != '0) begin
              state <= LOAD_I;
            end else if (dmem_words != '0) begin
              state <= LOAD_D;
            end else begin
              state      <= RUN;
              cpu_enable <= 1'b1;
              done       <= 1'b1;
            end
          end else if ((state == RUN) && !cpu_enable) begin
            cpu_enable <= 1'b1;
            done       <= 1'b1;
          end
        end

        LOAD_I, LOAD_D: begin
          if (handshake) begin
            if (state == LOAD_I) begin
              imem_wen_ext   <= 1'b1;
              imem_addr_ext  <= word_addr;
              imem_wdata_ext <= in_data;
            end else begin
              dmem_wen_ext   <= 1'b1;
              dmem_addr_ext  <= word_addr;
              dmem_wdata_ext <= in_data;
            end
`ifdef CPU_LOADER_VERIFY_EN
            state   <= VERIFY;
            v_phase <= 2'd0;
            v_dmem  <= (state == LOAD_D);
            v_last  <= last_word;
            v_data  <= in_data;
`else
            if (last_word) begin
              word_idx <= '0;
              state    <= ((state == LOAD_I) && (dmem_cnt != '0)) ? LOAD_D : RUN;
            end else begin
              word_idx <= idx_next;
            end
`endif
          end
        end

`ifdef CPU_LOADER_VERIFY_EN
        // Phase 0 is the write cycle, phase 1 the read strobe, phase 2 sees the read data.
        VERIFY: begin
          case (v_phase)
            2'd0: begin
              imem_ren_ext <= !v_dmem;
              dmem_ren_ext <= v_dmem;
              v_phase      <= 2'd1;
            end
            2'd1: v_phase <= 2'd2;
            default: begin
              v_phase <= 2'd0;
              if (v_rdata != v_data) begin
                state <= ERROR;
              end else if (v_last) begin
                word_idx <= '0;
                if (!v_dmem && (dmem_cnt != '0)) begin
                  state <= LOAD_D;
                end else begin
                  state      <= RUN;
                  cpu_enable <= 1'b1;
                  done       <= 1'b1;
                end
              end else begin
                word_idx <= idx_next;
                state    <= v_dmem ? LOAD_D : LOAD_I;
              end
            end
          endcase
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule
